// File: rtl/reduce_pkg.sv
// reduce_pkg: shared definitions for the reduce_sequencer block.
//   - op code constants (low two bits select the reduction kind, bit 2 inverts)
//   - controller state encoding
//   - helpers for identity value, dominant value and inversion of an op
package reduce_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Kind 2'b11 has no reduction defined.
    function automatic logic op_illegal(input logic [2:0] op);
        return op[1:0] == 2'b11;
    endfunction

    // Accumulator start value: 1 for the AND family, 0 for OR/XOR.
    function automatic logic op_identity(input logic [1:0] kind);
        return kind == OP_AND[1:0];
    endfunction

    // AND and OR families have a value that fixes the result once reached.
    function automatic logic op_has_dominant(input logic [1:0] kind);
        return kind[1] == 1'b0;
    endfunction

    // 0 dominates AND, 1 dominates OR.
    function automatic logic op_dominant(input logic [1:0] kind);
        return kind[0];
    endfunction

    function automatic logic op_inverts(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

endpackage

// File: rtl/reduce_chunk.sv
// reduce_chunk: combinational single-chunk reduction step.
// Ports:
//   chunk     in  CHUNK  operand slice reduced this cycle
//   kind      in  2      reduction kind (op code low bits)
//   acc       in  1      running accumulator
//   acc_next  out 1      accumulator after folding in this chunk
//   exit_now  out 1      accumulator reached the dominant value (early exit)
module reduce_chunk
    import reduce_pkg::*;
#(
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic [1:0]       kind,
    input  logic             acc,
    output logic             acc_next,
    output logic             exit_now
);

    always_comb begin
        acc_next = acc;
        exit_now = 1'b0;
        case (kind)
            OP_AND[1:0]: acc_next = acc & (&chunk);
            OP_OR[1:0]:  acc_next = acc | (|chunk);
            OP_XOR[1:0]: acc_next = acc ^ (^chunk);
            default:     acc_next = acc;
        endcase
        // Case equality keeps an x accumulator from ever triggering the
        // exit in simulation; synthesis sees an ordinary compare.
        if ((EARLY_EXIT != 0) && op_has_dominant(kind)) begin
            exit_now = (acc_next === op_dominant(kind));
        end
    end

endmodule

// File: rtl/reduce_sequencer.sv
// reduce_sequencer: multi-cycle wide reduction controller.
// Accepts a WIDTH-bit operand and op code, folds one CHUNK-bit slice per
// clock (least-significant first) and returns a 1-bit result.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      request handshake
//   in_op, in_data         op code and operand
//   out_valid/out_ready    result handshake
//   out_result             reduction result (inverted for NAND/NOR/XNOR)
//   out_err                op code was illegal
//   out_chunks             chunks consumed, saturating at WIDTH/CHUNK
// WIDTH must be a multiple of CHUNK.
module reduce_sequencer
    import reduce_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [2:0]                         in_op,
    input  logic [WIDTH-1:0]                   in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_result,
    output logic                               out_err,
    output logic [$clog2(WIDTH/CHUNK):0]       out_chunks
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic             acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             acc_next;
    logic             exit_now;

    // The operand register shifts right each RUN cycle, so the current
    // chunk is always the low slice and no wide index mux is needed.
    reduce_chunk #(
        .CHUNK      (CHUNK),
        .EARLY_EXIT (EARLY_EXIT)
    ) u_chunk (
        .chunk    (operand_q[CHUNK-1:0]),
        .kind     (op_q[1:0]),
        .acc      (acc_q),
        .acc_next (acc_next),
        .exit_now (exit_now)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_AND;
            operand_q <= '0;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d      = in_op;
                    operand_d = in_data;
                    cnt_d     = '0;
                    if (op_illegal(in_op)) begin
                        err_d   = 1'b1;
                        acc_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        acc_d   = op_identity(in_op[1:0]);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                acc_d     = acc_next;
                cnt_d     = cnt_q + 1'b1;
                operand_d = operand_q >> CHUNK;
                if ((cnt_q == LAST) || exit_now) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_err    = out_valid & err_q;
    assign out_chunks = out_valid ? cnt_q : '0;
    assign out_result = (out_valid && !err_q) ? (acc_q ^ op_inverts(op_q)) : 1'b0;

endmodule

// File: tb/tb_reduce_sequencer.sv
// Testbench for reduce_sequencer (WIDTH=32, CHUNK=4, EARLY_EXIT=1).
// Expected values come from a whole-operand reduction model.
module tb_reduce_sequencer;

    localparam int WIDTH      = 32;
    localparam int CHUNK      = 4;
    localparam int EARLY_EXIT = 1;
    localparam int N          = WIDTH / CHUNK;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [2:0]                in_op = 3'b000;
    logic [WIDTH-1:0]          in_data = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic                      out_result;
    logic                      out_err;
    logic [$clog2(N):0]        out_chunks;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reduce_sequencer #(
        .WIDTH      (WIDTH),
        .CHUNK      (CHUNK),
        .EARLY_EXIT (EARLY_EXIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .out_chunks (out_chunks)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Reference: full-width Verilog reduction of the operand; chunk count is
    // the first chunk whose own reduction equals the dominant value.
    task automatic model(input logic [2:0] op, input logic [WIDTH-1:0] d,
                         output logic res, output int nch, output logic err);
        logic             base;
        logic             part_r;
        logic [CHUNK-1:0] part;
        err  = 1'b0;
        nch  = N;
        res  = 1'b0;
        base = 1'b0;
        if (op[1:0] == 2'b11) begin
            err = 1'b1;
            nch = 0;
        end else begin
            case (op[1:0])
                2'b00:   base = &d;
                2'b01:   base = |d;
                default: base = ^d;
            endcase
            res = op[2] ? ~base : base;
            if (EARLY_EXIT != 0 && op[1] == 1'b0) begin
                for (int i = 0; i < N; i++) begin
                    part   = d[i*CHUNK +: CHUNK];
                    part_r = (op[0] == 1'b0) ? (&part) : (|part);
                    if (part_r === op[0]) begin
                        nch = i + 1;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic run_txn(input string tag, input logic [2:0] op,
                           input logic [WIDTH-1:0] d, input int hold);
        logic er;
        int   en;
        logic ee;
        int   lat;
        model(op, d, er, en, ee);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_op    = op;
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Garbage while busy: must be ignored and must not disturb the operand.
        in_data = ~d;
        in_op   = 3'b001;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        if (ee) check({tag, " latency"}, 32'(lat <= 1), 32'd1);
        else    check({tag, " latency"}, 32'(lat), 32'(en));
        check({tag, " result"}, 32'(out_result), 32'(er));
        check({tag, " chunks"}, 32'(out_chunks), 32'(en));
        check({tag, " err"}, 32'(out_err), 32'(ee));
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold result"}, 32'(out_result), 32'(er));
            check({tag, " hold chunks"}, 32'(out_chunks), 32'(en));
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
        $display("txn %s op=%b data=%h result=%b chunks=%0d err=%b latency=%0d",
                 tag, op, d, er, en, ee, lat);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic [2:0]       op;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_result", 32'(out_result), 32'd0);
        check("reset out_err", 32'(out_err), 32'd0);
        check("reset out_chunks", 32'(out_chunks), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_txn("and_ones", 3'b000, 32'hFFFF_FFFF, 0);
        run_txn("nand_ones", 3'b100, 32'hFFFF_FFFF, 0);
        run_txn("and_low0", 3'b000, 32'hFFFF_FFF0, 0);
        run_txn("and_high0", 3'b000, 32'h0FFF_FFFF, 0);
        for (int v = 0; v < 16; v++) begin
            d = 32'hFFFF_FFF0 | 32'(v);
            run_txn("sweep", 3'b000, d, 0);
        end
        run_txn("xor_1", 3'b010, 32'h0000_0001, 0);
        run_txn("xnor_1", 3'b110, 32'h0000_0001, 0);
        run_txn("xor_81", 3'b010, 32'h8000_0001, 0);
        run_txn("or_zero", 3'b001, 32'h0000_0000, 0);
        run_txn("nor_hi", 3'b101, 32'h0100_0000, 0);

        // 4-state operands
        d = 32'hFFFF_FFFF;
        d[0] = 1'bx;
        run_txn("and_x", 3'b000, d, 0);
        d[4] = 1'b0;
        run_txn("and_x_0", 3'b000, d, 0);

        // Back-pressure hold
        run_txn("hold5", 3'b010, 32'h1234_5678, 5);

        // Illegal op codes
        run_txn("illegal3", 3'b011, 32'hFFFF_FFFF, 2);
        run_txn("illegal7", 3'b111, 32'h0000_0000, 0);

        // Reset in the middle of RUN
        in_op    = 3'b000;
        in_data  = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst out_chunks", 32'(out_chunks), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("postrst out_valid", 32'(out_valid), 32'd0);
        check("postrst in_ready", 32'(in_ready), 32'd1);
        $display("txn midrun_reset recovered in_ready=%b out_valid=%b", in_ready, out_valid);
        run_txn("after_rst", 3'b000, 32'hFFFF_FFFF, 1);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            op = 3'($urandom_range(0, 7));
            case (op[1:0])
                2'b00: begin
                    d = '1;
                    repeat ($urandom_range(0, 2)) d[$urandom_range(0, WIDTH-1)] = 1'b0;
                end
                2'b01: begin
                    d = '0;
                    repeat ($urandom_range(0, 2)) d[$urandom_range(0, WIDTH-1)] = 1'b1;
                end
                default: d = $urandom();
            endcase
            run_txn("rand", op, d, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
